// File: rtl/idct_pkg.sv
// Types and constants shared by the row IDCT, transpose and column IDCT stages.
package idct_pkg;

  localparam int BLOCK_DIM       = 8;
  localparam int ROW_IDX_W       = 3;
  localparam int IDCT_COEF_WIDTH = 16;

  localparam logic [ROW_IDX_W-1:0] LAST_IDX = 3'd7;

  typedef logic [BLOCK_DIM-1:0][IDCT_COEF_WIDTH-1:0] coef_vec_t;

endpackage

// File: rtl/nasti_stream_channel.sv
// Stream channel carrying one vector of BLOCK_DIM coefficients per beat.
interface nasti_stream_channel #(
  parameter int N_ELEM = 8,
  parameter int ELEM_W = 16,
  parameter int ID_W   = 4,
  parameter int DEST_W = 4,
  parameter int USER_W = 4
);

  localparam int DATA_W = N_ELEM * ELEM_W;

  logic                           t_valid;
  logic                           t_ready;
  logic [N_ELEM-1:0][ELEM_W-1:0]  t_data;
  logic [DATA_W/8-1:0]            t_strb;
  logic [DATA_W/8-1:0]            t_keep;
  logic                           t_last;
  logic [ID_W-1:0]                t_id;
  logic [DEST_W-1:0]              t_dest;
  logic [USER_W-1:0]              t_user;

  modport master (
    output t_valid, t_data, t_strb, t_keep, t_last, t_id, t_dest, t_user,
    input  t_ready
  );

  modport slave (
    input  t_valid, t_data, t_strb, t_keep, t_last, t_id, t_dest, t_user,
    output t_ready
  );

endinterface

// File: rtl/idct_transpose_bank.sv
// One 8x8 transpose bank: row write port, row-written mask, and a
// combinational column read that zero-fills rows not written in this block.
module idct_transpose_bank
  import idct_pkg::*;
#(
  parameter int COEF_WIDTH = IDCT_COEF_WIDTH
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  wr_en_i,
  input  logic [ROW_IDX_W-1:0]                  wr_row_i,
  input  logic [BLOCK_DIM-1:0][COEF_WIDTH-1:0]  wr_data_i,
  input  logic                                  clr_i,
  input  logic [ROW_IDX_W-1:0]                  rd_col_i,
  output logic [BLOCK_DIM-1:0][COEF_WIDTH-1:0]  rd_data_o
);

  typedef logic [BLOCK_DIM-1:0][COEF_WIDTH-1:0] vec_t;

  vec_t                 mem_q [BLOCK_DIM];
  logic [BLOCK_DIM-1:0] mask_q;
  logic [BLOCK_DIM-1:0] mask_d;

  // Contents are never reset; the mask alone decides what is visible.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_row_i] <= wr_data_i;
    end
  end

  always_comb begin
    mask_d = mask_q;
    if (clr_i) begin
      mask_d = '0;
    end
    if (wr_en_i) begin
      mask_d[wr_row_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mask_q <= '0;
    end else begin
      mask_q <= mask_d;
    end
  end

  for (genvar gi = 0; gi < BLOCK_DIM; gi++) begin : g_col_rd
    assign rd_data_o[gi] = mask_q[gi] ? mem_q[gi][rd_col_i] : '0;
  end

endmodule

// File: rtl/stream_idct_transpose.sv
// Ping-pong 8x8 transpose between the row and column IDCT passes:
// rows in, columns out, one beat per cycle on each side.
module stream_idct_transpose
  import idct_pkg::*;
#(
  parameter int COEF_WIDTH = IDCT_COEF_WIDTH
) (
  input  logic                aclk,
  input  logic                areset,
  nasti_stream_channel.slave  in_ch,
  nasti_stream_channel.master out_ch
);

  typedef logic [BLOCK_DIM-1:0][COEF_WIDTH-1:0] vec_t;

  logic [1:0]           full_q, full_d;
  logic [1:0]           last_q, last_d;
  logic                 wr_sel_q, wr_sel_d;
  logic [ROW_IDX_W-1:0] wr_row_q, wr_row_d;
  logic                 rd_sel_q, rd_sel_d;
  logic [ROW_IDX_W-1:0] rd_col_q, rd_col_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_last_q, out_last_d;
  vec_t                 out_data_q, out_data_d;

  vec_t                 in_data;
  vec_t                 bank_rd [2];
  logic [1:0]           bank_wr_en;
  logic [1:0]           bank_clr;

  logic in_ready;
  logic wr_fire;
  logic wr_term;
  logic out_free;
  logic rd_load;
  logic rd_done;
  logic unused_in;

  assign in_data   = in_ch.t_data;
  assign unused_in = ^{in_ch.t_strb, in_ch.t_keep, in_ch.t_id, in_ch.t_dest, in_ch.t_user};

  // full gates both sides, so writer and reader never share a bank.
  assign in_ready = !areset && !full_q[wr_sel_q];
  assign wr_fire  = in_ch.t_valid && in_ready;
  assign wr_term  = wr_fire && ((wr_row_q == LAST_IDX) || in_ch.t_last);
  assign out_free = !out_valid_q || out_ch.t_ready;
  assign rd_load  = full_q[rd_sel_q] && out_free;
  assign rd_done  = rd_load && (rd_col_q == LAST_IDX);

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    assign bank_wr_en[gi] = wr_fire && (wr_sel_q == 1'(gi));
    assign bank_clr[gi]   = rd_done && (rd_sel_q == 1'(gi));

    idct_transpose_bank #(
      .COEF_WIDTH (COEF_WIDTH)
    ) u_bank (
      .clk_i     (aclk),
      .rst_i     (areset),
      .wr_en_i   (bank_wr_en[gi]),
      .wr_row_i  (wr_row_q),
      .wr_data_i (in_data),
      .clr_i     (bank_clr[gi]),
      .rd_col_i  (rd_col_q),
      .rd_data_o (bank_rd[gi])
    );
  end

  always_comb begin
    full_d      = full_q;
    last_d      = last_q;
    wr_sel_d    = wr_sel_q;
    wr_row_d    = wr_row_q;
    rd_sel_d    = rd_sel_q;
    rd_col_d    = rd_col_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;

    if (wr_fire) begin
      if (wr_term) begin
        full_d[wr_sel_q] = 1'b1;
        last_d[wr_sel_q] = in_ch.t_last;
        wr_sel_d         = !wr_sel_q;
        wr_row_d         = '0;
      end else begin
        wr_row_d = wr_row_q + 3'd1;
      end
    end

    if (rd_load) begin
      out_valid_d = 1'b1;
      out_data_d  = bank_rd[rd_sel_q];
      out_last_d  = last_q[rd_sel_q] && (rd_col_q == LAST_IDX);
      if (rd_done) begin
        full_d[rd_sel_q] = 1'b0;
        rd_sel_d         = !rd_sel_q;
        rd_col_d         = '0;
      end else begin
        rd_col_d = rd_col_q + 3'd1;
      end
    end else if (out_ch.t_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      full_q      <= '0;
      last_q      <= '0;
      wr_sel_q    <= 1'b0;
      wr_row_q    <= '0;
      rd_sel_q    <= 1'b0;
      rd_col_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      full_q      <= full_d;
      last_q      <= last_d;
      wr_sel_q    <= wr_sel_d;
      wr_row_q    <= wr_row_d;
      rd_sel_q    <= rd_sel_d;
      rd_col_q    <= rd_col_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  assign in_ch.t_ready  = in_ready;
  assign out_ch.t_valid = out_valid_q;
  assign out_ch.t_data  = out_data_q;
  assign out_ch.t_last  = out_last_q;
  assign out_ch.t_strb  = '1;
  assign out_ch.t_keep  = '1;
  assign out_ch.t_id    = '0;
  assign out_ch.t_dest  = '0;
  assign out_ch.t_user  = '0;

endmodule
